// File: rtl/uart_fifo_core_if.sv
// Handshake and status bundle between uart_fifo_core and its user logic.
interface uart_fifo_core_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] i_tx_data;
   logic                 i_tx_valid;
   logic                 o_tx_ready;
   logic                 o_tx_busy;
   logic [DATA_BITS-1:0] o_rx_data;
   logic                 o_rx_valid;
   logic                 i_rx_ready;
   logic                 o_parity_err;
   logic                 o_frame_err;
   logic                 o_overrun;
   logic                 i_clr_overrun;

   modport slave (
      input  i_tx_data, i_tx_valid, i_rx_ready, i_clr_overrun,
      output o_tx_ready, o_tx_busy, o_rx_data, o_rx_valid,
             o_parity_err, o_frame_err, o_overrun
   );

   modport master (
      output i_tx_data, i_tx_valid, i_rx_ready, i_clr_overrun,
      input  o_tx_ready, o_tx_busy, o_rx_data, o_rx_valid,
             o_parity_err, o_frame_err, o_overrun
   );
endinterface

// File: rtl/uart_fifo_core.sv
// Full-duplex UART: TX FIFO feeding a frame serializer, RX deserializer with valid/ready
// output and parity/framing/overrun status. Frame format is fixed by parameters.
module uart_fifo_core #(
   parameter int DATA_BITS       = 8,
   parameter int PARITY_MODE     = 0,
   parameter int STOP_BITS       = 1,
   parameter int TIMER_BITS      = 10,
   parameter int CLOCKS_PER_BAUD = 868,
   parameter int HALF_PER_BAUD   = 434,
   parameter int FIFO_AW         = 4
) (
   input  logic              clk,
   input  logic              i_reset,
   uart_fifo_core_if.slave   bus,
   input  logic              uart_txd_in,
   output logic              uart_rxd_out
);
   localparam int DEPTH = 2**FIFO_AW;
   localparam logic [TIMER_BITS-1:0] BAUD_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
   localparam logic [TIMER_BITS-1:0] HALF_RELOAD = TIMER_BITS'(HALF_PER_BAUD - 1);
   localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic       ODD       = (PARITY_MODE == 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]     count_q, count_d;
   logic                 push, pop, tx_ready;

   assign tx_ready = (count_q != (FIFO_AW+1)'(DEPTH));
   assign push     = bus.i_tx_valid & tx_ready;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.i_tx_data;
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // ---------------- TX FSM ----------------
   state_t                tx_state_q, tx_state_d;
   logic [TIMER_BITS-1:0] tx_timer_q, tx_timer_d;
   logic [3:0]            tx_bits_q, tx_bits_d;
   logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
   logic                  tx_par_q, tx_par_d, txd_q, txd_d, tx_tick;

   assign tx_tick = (tx_timer_q == '0);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_timer_d = tx_timer_q;
      tx_bits_d  = tx_bits_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      pop        = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop        = 1'b1;
               tx_state_d = S_START;
               tx_timer_d = BAUD_RELOAD;
            end
         end
         S_START, S_DATA, S_PARITY, S_STOP: begin
            if (!tx_tick) begin
               tx_timer_d = tx_timer_q - 1'b1;
            end else begin
               tx_timer_d = BAUD_RELOAD;
               case (tx_state_q)
                  S_START: begin
                     tx_state_d = S_DATA;
                     tx_bits_d  = DATA_LAST;
                  end
                  S_DATA: begin
                     tx_shift_d = tx_shift_q >> 1;
                     tx_bits_d  = tx_bits_q - 1'b1;
                     if (tx_bits_q == '0) begin
                        tx_state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        tx_bits_d  = STOP_LAST;
                     end
                  end
                  S_PARITY: begin
                     tx_state_d = S_STOP;
                     tx_bits_d  = STOP_LAST;
                  end
                  default: begin
                     tx_bits_d = tx_bits_q - 1'b1;
                     if (tx_bits_q == '0) begin
                        // back-to-back frames: pop straight from STOP, no idle bit-time
                        if (count_q != '0) begin
                           pop        = 1'b1;
                           tx_state_d = S_START;
                        end else begin
                           tx_state_d = S_IDLE;
                        end
                     end
                  end
               endcase
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      if (pop) begin
         tx_shift_d = mem_q[rd_ptr_q];
         tx_par_d   = (^mem_q[rd_ptr_q]) ^ ODD;
      end
      case (tx_state_q)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = tx_shift_q[0];
         S_PARITY: txd_d = tx_par_q;
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         tx_state_q <= S_IDLE;
         tx_timer_q <= '0;
         tx_bits_q  <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_timer_q <= tx_timer_d;
         tx_bits_q  <= tx_bits_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         txd_q      <= txd_d;
      end
   end

   assign uart_rxd_out   = txd_q;
   assign bus.o_tx_ready = tx_ready;
   assign bus.o_tx_busy  = (count_q != '0) || (tx_state_q != S_IDLE);

   // ---------------- RX path ----------------
   state_t                rx_state_q, rx_state_d;
   logic [TIMER_BITS-1:0] rx_timer_q, rx_timer_d;
   logic [3:0]            rx_bits_q, rx_bits_d;
   logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
   logic                  sync1_q, sync2_q, prev_q;
   logic                  rx_par_q, rx_par_d, rx_tick, rx_done;
   logic                  rx_valid_q, rx_valid_d, perr_q, perr_d, ferr_q, ferr_d;
   logic                  ovr_q, ovr_d;

   assign rx_tick = (rx_timer_q == '0);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_timer_d = rx_timer_q - 1'b1;
      rx_bits_d  = rx_bits_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      rx_done    = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            rx_timer_d = rx_timer_q;
            if (prev_q && !sync2_q) begin
               rx_state_d = S_START;
               rx_timer_d = HALF_RELOAD;
            end
         end
         S_START: if (rx_tick) begin
            rx_timer_d = BAUD_RELOAD;
            rx_bits_d  = DATA_LAST;
            rx_state_d = sync2_q ? S_IDLE : S_DATA;
         end
         S_DATA: if (rx_tick) begin
            rx_timer_d = BAUD_RELOAD;
            rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bits_d  = rx_bits_q - 1'b1;
            if (rx_bits_q == '0) rx_state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: if (rx_tick) begin
            rx_timer_d = BAUD_RELOAD;
            rx_par_d   = sync2_q;
            rx_state_d = S_STOP;
         end
         S_STOP: if (rx_tick) begin
            rx_done    = 1'b1;
            rx_state_d = S_IDLE;
         end
         default: rx_state_d = S_IDLE;
      endcase

      rx_data_d  = rx_data_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      rx_valid_d = rx_valid_q & ~bus.i_rx_ready;
      ovr_d      = ovr_q & ~bus.i_clr_overrun;
      if (rx_done) begin
         if (!rx_valid_q || bus.i_rx_ready) begin
            rx_data_d  = rx_shift_q;
            perr_d     = (PARITY_MODE != 0) && (rx_par_q != ((^rx_shift_q) ^ ODD));
            ferr_d     = ~sync2_q;
            rx_valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_timer_q <= '0;
         rx_bits_q  <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         sync1_q    <= uart_txd_in;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         rx_state_q <= rx_state_d;
         rx_timer_q <= rx_timer_d;
         rx_bits_q  <= rx_bits_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign bus.o_rx_data    = rx_data_q;
   assign bus.o_rx_valid   = rx_valid_q;
   assign bus.o_parity_err = perr_q;
   assign bus.o_frame_err  = ferr_q;
   assign bus.o_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_fifo_core.sv
// Randomized and directed bench for uart_fifo_core against a frame-level reference model.
module tb_uart_fifo_core;
   localparam int CPB  = 16;
   localparam int HALF = 8;

   logic clk, rst;
   logic lb0, drv0, rx0, tx0;
   logic lb2, drv2, rx2, tx2;
   logic rx1, tx1;
   int   mon_sel;
   logic mon_line;

   int vectors, miscompares;
   logic [7:0] exp_w [0:7];
   logic [7:0] rx_got [$];

   uart_fifo_core_if #(.DATA_BITS(8)) if0 ();
   uart_fifo_core_if #(.DATA_BITS(8)) if1 ();
   uart_fifo_core_if #(.DATA_BITS(8)) if2 ();

   assign rx0 = lb0 ? tx0 : drv0;
   assign rx1 = tx1;
   assign rx2 = lb2 ? tx2 : drv2;
   assign mon_line = (mon_sel == 0) ? tx0 : (mon_sel == 1) ? tx1 : tx2;

   uart_fifo_core #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .TIMER_BITS(10),
                    .CLOCKS_PER_BAUD(CPB), .HALF_PER_BAUD(HALF), .FIFO_AW(2))
      dut0 (.clk(clk), .i_reset(rst), .bus(if0.slave), .uart_txd_in(rx0), .uart_rxd_out(tx0));
   uart_fifo_core #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .TIMER_BITS(10),
                    .CLOCKS_PER_BAUD(CPB), .HALF_PER_BAUD(HALF), .FIFO_AW(2))
      dut1 (.clk(clk), .i_reset(rst), .bus(if1.slave), .uart_txd_in(rx1), .uart_rxd_out(tx1));
   uart_fifo_core #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .TIMER_BITS(10),
                    .CLOCKS_PER_BAUD(CPB), .HALF_PER_BAUD(HALF), .FIFO_AW(2))
      dut2 (.clk(clk), .i_reset(rst), .bus(if2.slave), .uart_txd_in(rx2), .uart_rxd_out(tx2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (if0.o_rx_valid && if0.i_rx_ready) rx_got.push_back(if0.o_rx_data);

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line level of bit idx of a frame, straight from the frame format rules.
   function automatic logic frame_bit(input logic [7:0] w, input int idx, input int pm);
      logic odd_ones;
      odd_ones = ($countones(w) % 2) == 1;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return w[idx-1];
      if (pm != 0 && idx == 9) return (pm == 2) ? odd_ones : ~odd_ones;
      return 1'b1;
   endfunction

   task automatic sample_tx(input int nwords, input int pm, input int st);
      int c, flen;
      c = 0;
      flen = 9 + ((pm != 0) ? 1 : 0) + st;
      while (mon_line !== 1'b0 && c < 2000) begin
         @(posedge clk); #1; c++;
      end
      chk("tx_start_seen", mon_line, 0);
      repeat (CPB/2) @(posedge clk);
      #1;
      for (int w = 0; w < nwords; w++)
         for (int b = 0; b < flen; b++) begin
            if (w != 0 || b != 0) begin
               repeat (CPB) @(posedge clk);
               #1;
            end
            chk($sformatf("tx_bit w%0d b%0d", w, b), mon_line, frame_bit(exp_w[w], b, pm));
         end
   endtask

   task automatic push0(input logic [7:0] d);
      int c;
      c = 0;
      while (!if0.o_tx_ready && c < 3000) begin
         @(posedge clk); #1; c++;
      end
      if0.i_tx_data  = d;
      if0.i_tx_valid = 1'b1;
      @(posedge clk); #1;
      if0.i_tx_valid = 1'b0;
   endtask

   task automatic wait_rx(input int sel, input string tag);
      int c;
      logic v;
      c = 0;
      v = (sel == 0) ? if0.o_rx_valid : (sel == 1) ? if1.o_rx_valid : if2.o_rx_valid;
      while (!v && c < 3000) begin
         @(posedge clk); #1; c++;
         v = (sel == 0) ? if0.o_rx_valid : (sel == 1) ? if1.o_rx_valid : if2.o_rx_valid;
      end
      chk(tag, v, 1);
   endtask

   task automatic wait_idle0();
      int c;
      c = 0;
      while (if0.o_tx_busy && c < 5000) begin
         @(posedge clk); #1; c++;
      end
      chk("tx_idle_reached", if0.o_tx_busy, 0);
   endtask

   task automatic accept0();
      if0.i_rx_ready = 1'b1;
      @(posedge clk); #1;
      if0.i_rx_ready = 1'b0;
   endtask

   task automatic drive(input int sel, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel == 0) drv0 = bits[i];
         else          drv2 = bits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int cnt;
      logic [7:0] q_exp [$];
      vectors = 0; miscompares = 0;
      lb0 = 1'b1; drv0 = 1'b1; lb2 = 1'b1; drv2 = 1'b1; mon_sel = 0;
      if0.i_tx_data = '0; if0.i_tx_valid = 0; if0.i_rx_ready = 0; if0.i_clr_overrun = 0;
      if1.i_tx_data = '0; if1.i_tx_valid = 0; if1.i_rx_ready = 0; if1.i_clr_overrun = 0;
      if2.i_tx_data = '0; if2.i_tx_valid = 0; if2.i_rx_ready = 0; if2.i_clr_overrun = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd", tx0, 1);
      chk("rst_ready", if0.o_tx_ready, 1);
      chk("rst_busy", if0.o_tx_busy, 0);
      chk("rst_valid", if0.o_rx_valid, 0);
      chk("rst_data", if0.o_rx_data, 0);
      chk("rst_flags", {if0.o_parity_err, if0.o_frame_err, if0.o_overrun}, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 8N1 loopback with start-bit latency
      exp_w[0] = 8'hA5;
      if0.i_tx_data = 8'hA5; if0.i_tx_valid = 1'b1;
      @(posedge clk); #1;
      if0.i_tx_valid = 1'b0;
      chk("busy_after_push", if0.o_tx_busy, 1);
      @(posedge clk); #1;
      chk("txd_edge_n1", tx0, 1);
      @(posedge clk); #1;
      chk("txd_edge_n2", tx0, 0);
      sample_tx(1, 0, 1);
      wait_rx(0, "rx_valid_a5");
      chk("rx_data_a5", if0.o_rx_data, 8'hA5);
      chk("rx_err_a5", {if0.o_parity_err, if0.o_frame_err}, 0);
      accept0();
      chk("rx_valid_cleared", if0.o_rx_valid, 0);

      // parity: odd (dut1) and even with two stop bits (dut2)
      exp_w[0] = 8'h07;
      mon_sel = 1;
      #1;
      fork
         begin
            if1.i_tx_data = 8'h07; if1.i_tx_valid = 1'b1;
            @(posedge clk); #1;
            if1.i_tx_valid = 1'b0;
         end
         sample_tx(1, 1, 1);
      join
      wait_rx(1, "rx_valid_odd");
      chk("rx_data_odd", if1.o_rx_data, 8'h07);
      chk("rx_perr_odd", if1.o_parity_err, 0);
      mon_sel = 2;
      #1;
      fork
         begin
            if2.i_tx_data = 8'h07; if2.i_tx_valid = 1'b1;
            @(posedge clk); #1;
            if2.i_tx_valid = 1'b0;
         end
         sample_tx(1, 2, 2);
      join
      wait_rx(2, "rx_valid_even");
      chk("rx_data_even", if2.o_rx_data, 8'h07);
      chk("rx_perr_even", if2.o_parity_err, 0);
      if2.i_rx_ready = 1'b1;
      @(posedge clk); #1;
      if2.i_rx_ready = 1'b0;

      // five words, valid held: FIFO fills, frames go out back-to-back
      mon_sel = 0;
      if0.i_rx_ready = 1'b1;
      rx_got.delete();
      for (int i = 0; i < 5; i++) exp_w[i] = 8'($urandom_range(0, 255));
      #1;
      fork
         begin
            if0.i_tx_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
               if0.i_tx_data = exp_w[i];
               cnt = 0;
               while (!if0.o_tx_ready && cnt < 3000) begin
                  @(posedge clk); #1; cnt++;
               end
               @(posedge clk); #1;
            end
            if0.i_tx_valid = 1'b0;
            chk("ready_low_full", if0.o_tx_ready, 0);
            cnt = 0;
            while (!if0.o_tx_ready && cnt < 400) begin
               @(posedge clk); #1; cnt++;
            end
            chk("ready_rise_cycles", cnt, 10*CPB - 3);
         end
         sample_tx(5, 0, 1);
      join
      chk("busy_in_last_stop", if0.o_tx_busy, 1);
      repeat (CPB) @(posedge clk);
      #1;
      chk("busy_after_last_stop", if0.o_tx_busy, 0);
      chk("b2b_rx_count", rx_got.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < rx_got.size()) chk($sformatf("b2b_rx %0d", i), rx_got[i], exp_w[i]);

      // randomized traffic with random gaps
      rx_got.delete();
      q_exp.delete();
      for (int i = 0; i < 6; i++) begin
         q_exp.push_back(8'($urandom_range(0, 255)));
         push0(q_exp[i]);
         repeat ($urandom_range(0, 200)) @(posedge clk);
         #1;
      end
      wait_idle0();
      repeat (3*CPB) @(posedge clk);
      #1;
      chk("rand_rx_count", rx_got.size(), q_exp.size());
      for (int i = 0; i < q_exp.size(); i++)
         if (i < rx_got.size()) chk($sformatf("rand_rx %0d", i), rx_got[i], q_exp[i]);

      // overrun: second word discarded, sticky until cleared
      if0.i_rx_ready = 1'b0;
      rx_got.delete();
      push0(8'h11);
      push0(8'h22);
      wait_idle0();
      repeat (3*CPB) @(posedge clk);
      #1;
      chk("ovr_valid", if0.o_rx_valid, 1);
      chk("ovr_data_held", if0.o_rx_data, 8'h11);
      chk("ovr_set", if0.o_overrun, 1);
      if0.i_clr_overrun = 1'b1;
      @(posedge clk); #1;
      if0.i_clr_overrun = 1'b0;
      chk("ovr_cleared", if0.o_overrun, 0);
      chk("ovr_data_after_clr", if0.o_rx_data, 8'h11);
      accept0();
      chk("ovr_rx_count", rx_got.size(), 1);

      // direct line drive: glitch, framing error, recovery
      lb0 = 1'b0; drv0 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      drv0 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      drv0 = 1'b1;
      repeat (3*CPB) @(posedge clk);
      #1;
      chk("glitch_no_valid", if0.o_rx_valid, 0);
      drive(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
      drv0 = 1'b0;
      repeat (2*CPB) @(posedge clk);
      #1;
      drv0 = 1'b1;
      repeat (2*CPB) @(posedge clk);
      #1;
      chk("ferr_valid", if0.o_rx_valid, 1);
      chk("ferr_data", if0.o_rx_data, 8'h3C);
      chk("ferr_flag", if0.o_frame_err, 1);
      accept0();
      drive(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
      repeat (CPB) @(posedge clk);
      #1;
      chk("recover_valid", if0.o_rx_valid, 1);
      chk("recover_data", if0.o_rx_data, 8'h5A);
      chk("recover_ferr", if0.o_frame_err, 0);
      accept0();
      lb0 = 1'b1;

      // flipped parity bit on the even-parity core
      lb2 = 1'b0; drv2 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      drive(2, {4'b0, 2'b11, 1'b0, 8'h07, 1'b0}, 12);
      wait_rx(2, "perr_valid");
      chk("perr_data", if2.o_rx_data, 8'h07);
      chk("perr_flag", if2.o_parity_err, 1);
      chk("perr_ferr", if2.o_frame_err, 0);
      lb2 = 1'b1;

      // reset mid-DATA aborts the frame
      push0(8'hC3);
      repeat (4*CPB + 3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_txd", tx0, 1);
      chk("midrst_ready", if0.o_tx_ready, 1);
      chk("midrst_busy", if0.o_tx_busy, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_w[0] = 8'h96;
      fork
         push0(8'h96);
         sample_tx(1, 0, 1);
      join
      wait_rx(0, "post_rst_valid");
      chk("post_rst_data", if0.o_rx_data, 8'h96);
      chk("post_rst_err", {if0.o_parity_err, if0.o_frame_err, if0.o_overrun}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
